// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a ROWS x COLS active-low keypad one row per
// slow tick, assembles a full-frame snapshot and debounces it frame by frame
// into a single accepted key with press/release events.
module keypad_matrix_scanner #(
  parameter int unsigned F_CLK          = 50000000,
  parameter int unsigned F_SCAN         = 1000,
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0]               col_in,
  output logic [ROWS-1:0]               row_out,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  output logic                          key_held,
  output logic                          key_release
);

  localparam int unsigned TICK_DIV = F_CLK / F_SCAN;
  localparam int unsigned TW       = $clog2(TICK_DIV);
  localparam int unsigned NK       = ROWS * COLS;
  localparam int unsigned CW       = $clog2(NK);
  localparam int unsigned RW       = $clog2(ROWS);
  localparam int unsigned DW       = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [DW-1:0] DB_ACCEPT = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;
  logic [RW-1:0]   row_ptr;
  logic [RW-1:0]   row_nxt;
  logic [NK-1:0]   snap;
  logic            frame_done;
  logic [1:0]      ones;
  logic [CW-1:0]   hit;
  logic            one_hit;
  logic            match;
  logic [CW-1:0]   cand;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   cnt_inc;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running row-advance divider; tick is its terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous column pins (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Next row to drive, wrapping after the last row.
  always_comb begin
    row_nxt = (row_ptr == ROW_LAST) ? '0 : row_ptr + RW'(1);
  end

  // Row scan: capture the driven row's columns, then move the low drive on.
  // frame_done marks that the last row of a frame has just been captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_ptr    <= '0;
      row_out    <= ~ROWS'(1);
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (row_ptr == ROW_LAST);
      if (tick) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          if (row_ptr == RW'(r)) begin
            snap[r*COLS +: COLS] <= ~col_sync;
          end
        end
        row_ptr <= row_nxt;
        row_out <= ~(ROWS'(1) << row_nxt);
      end
    end
  end

  // Frame classification: count set bits (saturating at 2) and remember the
  // position of the first one; only meaningful when exactly one is set.
  always_comb begin
    ones = 2'd0;
    hit  = '0;
    for (int unsigned i = 0; i < NK; i++) begin
      if (snap[i]) begin
        if (ones == 2'd0) begin
          ones = 2'd1;
          hit  = CW'(i);
        end else begin
          ones = 2'd2;
        end
      end
    end
    one_hit = (ones == 2'd1);
    match   = one_hit && (hit == cand);
  end

  // Saturating increment of the debounce counter.
  always_comb begin
    cnt_inc = (cnt >= DB_ACCEPT) ? DB_ACCEPT : cnt + DW'(1);
  end

  // Debounce FSM, stepped once per completed frame; event outputs are
  // single-cycle pulses cleared on every other clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (one_hit) begin
              cand  <= hit;
              cnt   <= DW'(1);
              state <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (match) begin
              if (cnt_inc == DB_ACCEPT) begin
                state     <= HELD;
                cnt       <= '0;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (!match) begin
              state <= REL_DB;
              cnt   <= DW'(1);
            end
          end
          REL_DB: begin
            if (match) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt_inc == DB_ACCEPT) begin
              state       <= IDLE;
              cnt         <= '0;
              key_held    <= 1'b0;
              key_release <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad model drives the columns from the
// pressed-key set, and a frame-level reference model predicts events.
module tb_keypad_matrix_scanner;

  localparam int DB    = 3;
  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_release;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int vtot   = 0;
  int rtot   = 0;
  bit overlap = 1'b0;
  bit armed   = 1'b0;

  // reference model state
  bit          m_held;
  int          m_code;
  int          m_run_key;
  int          m_run_len;
  int          m_rel_len;
  logic [15:0] prev_keys;
  bit          have_prev;

  keypad_matrix_scanner #(
    .F_CLK(1000),
    .F_SCAN(100),
    .ROWS(4),
    .COLS(4),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_in(col_in),
    .row_out(row_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  // Pulse accounting sampled on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      if (key_valid) vtot++;
      if (key_release) rtot++;
      if (key_valid && key_release) overlap = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held    = 1'b0;
    m_code    = 0;
    m_run_key = 0;
    m_run_len = 0;
    m_rel_len = 0;
    have_prev = 1'b0;
  endtask

  // One frame of evidence: press needs DB consecutive frames showing the same
  // single key starting from an idle decision; release needs DB consecutive
  // frames not showing exactly the held key.
  task automatic model_eval(input logic [15:0] m, output int ev, output int er);
    int  n;
    int  k;
    bit  single;
    ev = 0;
    er = 0;
    n  = $countones(m);
    k  = -1;
    for (int i = 15; i >= 0; i--) if (m[i]) k = i;
    single = (n == 1);
    if (!m_held) begin
      if (m_run_len > 0) begin
        if (single && k == m_run_key) begin
          m_run_len++;
          if (m_run_len == DB) begin
            m_held    = 1'b1;
            m_code    = k;
            ev        = 1;
            m_run_len = 0;
          end
        end else begin
          m_run_len = 0;
        end
      end else if (single) begin
        m_run_key = k;
        m_run_len = 1;
      end
    end else begin
      if (single && k == m_code) begin
        m_rel_len = 0;
      end else begin
        m_rel_len++;
        if (m_rel_len == DB) begin
          m_held    = 1'b0;
          er        = 1;
          m_rel_len = 0;
        end
      end
    end
  endtask

  // Hold one key pattern for a whole frame; the decision for the previous
  // frame lands inside this window and is checked at its end.
  task automatic frame(input logic [15:0] m);
    int v0;
    int r0;
    int ev;
    int er;
    keys = m;
    v0   = vtot;
    r0   = rtot;
    repeat (FRAME) @(posedge clk);
    #1;
    if (have_prev) begin
      model_eval(prev_keys, ev, er);
      check("valid_count", vtot - v0, ev);
      check("release_count", rtot - r0, er);
      check("held", key_held, m_held);
      check("code", key_code, m_code);
    end
    prev_keys = m;
    have_prev = 1'b1;
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) frame(m);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once and
  // stay quiet while reset is held. Returns on a falling edge so the next
  // rising edge is the first after reset.
  task automatic reset_mid();
    int v0;
    int r0;
    @(posedge clk);
    #3;
    rst   = 1'b1;
    armed = 1'b1;
    #1;
    check("rst_row_out", row_out, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_release", key_release, 0);
    v0 = vtot;
    r0 = rtot;
    repeat (3) @(negedge clk);
    check("rst_quiet", (vtot - v0) + (rtot - r0), 0);
    rst = 1'b0;
    model_reset();
  endtask

  localparam logic [15:0] K9 = 16'h0200;
  localparam logic [15:0] K0 = 16'h0001;
  localparam logic [15:0] K5 = 16'h0020;

  initial begin
    logic [15:0] pat;
    int sel;
    int len;
    int last_k;
    int a;
    int b;
    int v0;
    int v1;
    int r0;
    int waited;

    model_reset();
    repeat (2) @(posedge clk);
    reset_mid();

    // r2c1 held, brief one-frame gap, then released
    frames(K9, 8);
    frames('0, 1);
    frames(K9, 3);
    frames('0, 4);
    // two-key chord must never be accepted
    frames(K0 | K5, 10);
    frames('0, 2);
    // async reset while a key is held
    frames(K9, 5);
    reset_mid();

    // randomized pattern runs
    last_k = 9;
    for (int s = 0; s < 30; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 5);
      if (sel < 3) begin
        pat = '0;
      end else if (sel < 8) begin
        if ($urandom_range(0, 1) == 1) last_k = $urandom_range(0, 15);
        pat = 16'(1) << last_k;
      end else begin
        a   = $urandom_range(0, 15);
        b   = (a + $urandom_range(1, 15)) % 16;
        pat = (16'(1) << a) | (16'(1) << b);
      end
      frames(pat, len);
    end
    frames('0, 4);

    // reset two frames into press debounce; a full debounce is needed after
    reset_mid();
    frames(K9, 2);
    reset_mid();
    frames(K9, 5);
    frames('0, 4);

    // bouncing press, then stable, then release
    reset_mid();
    v0 = vtot;
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) keys[9] = ~keys[9];
      @(posedge clk);
      #1;
    end
    keys = K9;
    repeat (300) @(posedge clk);
    #1;
    check("bounce_valid_once", vtot - v0, 1);
    check("bounce_code", key_code, 9);
    check("bounce_held", key_held, 1);

    v1     = vtot;
    r0     = rtot;
    keys   = '0;
    waited = 0;
    while (rtot == r0 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("release_in_budget", rtot - r0, 1);
    check("release_held", key_held, 0);
    check("release_code", key_code, 9);
    repeat (100) @(posedge clk);
    #1;
    check("release_once", rtot - r0, 1);
    check("release_no_valid", vtot - v1, 0);

    check("valid_release_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
